// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back controller.
package wb_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned DATA_W    = 64;

  // XZR: writes to this index are accepted but never reach the register file.
  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd31;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_ctrl_if.sv
// Producer / register-file / forwarding signals of the write-back controller.
interface regfile_writeback_ctrl_if;
  import wb_pkg::*;

  logic                 AluValid;
  logic [REG_IDX_W-1:0] AluRd;
  logic [DATA_W-1:0]    AluData;
  logic                 AluReady;

  logic                 LdValid;
  logic [REG_IDX_W-1:0] LdRd;
  logic [DATA_W-1:0]    LdData;
  logic                 LdReady;

  logic                 RegWr;
  logic [REG_IDX_W-1:0] RW;
  logic [DATA_W-1:0]    BusW;

  logic [REG_IDX_W-1:0] FwdRA;
  logic [REG_IDX_W-1:0] FwdRB;
  logic                 FwdHitA;
  logic                 FwdHitB;
  logic [DATA_W-1:0]    FwdDataA;
  logic [DATA_W-1:0]    FwdDataB;

  // Pipeline side: offers results, issues forwarding queries, observes writes.
  modport master (
    output AluValid, AluRd, AluData, LdValid, LdRd, LdData, FwdRA, FwdRB,
    input  AluReady, LdReady, RegWr, RW, BusW, FwdHitA, FwdHitB, FwdDataA, FwdDataB
  );

  // Write-back controller side.
  modport slave (
    input  AluValid, AluRd, AluData, LdValid, LdRd, LdData, FwdRA, FwdRB,
    output AluReady, LdReady, RegWr, RW, BusW, FwdHitA, FwdHitB, FwdDataA, FwdDataB
  );

endinterface

// File: rtl/wb_fifo.sv
// Dual-push / single-pop circular buffer of pending writes.
// push0 is always stored older than push1 when both fire in one cycle.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push0,
  input  wb_entry_t                 pushData0,
  input  logic                      push1,
  input  wb_entry_t                 pushData1,
  input  logic                      pop,
  output logic [$clog2(DEPTH):0]    count,
  output logic [$clog2(DEPTH)-1:0]  rdPtr,
  output wb_entry_t                 head,
  output wb_entry_t                 entries [DEPTH],
  output logic [DEPTH-1:0]          entryValid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] push1Idx;
  logic [CNT_W-1:0] pushCnt;
  logic [DEPTH-1:0] validNext;

  assign head     = entries[rdPtr];
  assign pushCnt  = CNT_W'(push0) + CNT_W'(push1);
  assign push1Idx = push0 ? wrPtr + PTR_W'(1) : wrPtr;

  // Valid bits: retire the head on pop, then mark newly written slots.
  always_comb begin
    validNext = entryValid;
    if (pop)   validNext[rdPtr]    = 1'b0;
    if (push0) validNext[wrPtr]    = 1'b1;
    if (push1) validNext[push1Idx] = 1'b1;
  end

  // Pointer, occupancy and valid-bit state.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      rdPtr      <= '0;
      wrPtr      <= '0;
      entryValid <= '0;
    end else begin
      count      <= count + pushCnt - CNT_W'(pop);
      rdPtr      <= rdPtr + PTR_W'(pop);
      wrPtr      <= wrPtr + PTR_W'(pushCnt);
      entryValid <= validNext;
    end
  end

  // Entry payload storage; contents are qualified by entryValid.
  always_ff @(posedge clk) begin
    if (push0) entries[wrPtr]    <= pushData0;
    if (push1) entries[push1Idx] <= pushData1;
  end

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Write-back controller: accepts ALU/load results, queues them in order and
// drains one register-file write per cycle. Writes to XZR are swallowed.
// Optional forwarding CAM is built when WB_FORWARD_EN is defined.
module regfile_writeback_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic                     Clk,
  input logic                     Reset,
  regfile_writeback_ctrl_if.slave wb
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] freeSlots;
  logic [PTR_W-1:0] rdPtr;
  wb_entry_t        head;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] entryValid;
  logic             aluTakes;
  logic             aluPush;
  logic             ldPush;
  logic             pop;
  wb_entry_t        aluEntry;
  wb_entry_t        ldEntry;

  assign freeSlots = CNT_W'(DEPTH) - count;
  assign aluTakes  = wb.AluValid && (wb.AluRd != ZERO_REG);
  assign aluEntry  = '{rd: wb.AluRd, data: wb.AluData};
  assign ldEntry   = '{rd: wb.LdRd,  data: wb.LdData};

  // Handshake: readies never count on this cycle's pop; XZR is accepted but not queued.
  always_comb begin
    wb.AluReady = 1'b0;
    wb.LdReady  = 1'b0;
    if (!Reset) begin
      wb.AluReady = (freeSlots != '0);
      wb.LdReady  = (freeSlots >= (CNT_W'(1) + CNT_W'(aluTakes)));
    end
    aluPush = aluTakes && wb.AluReady;
    ldPush  = wb.LdValid && wb.LdReady && (wb.LdRd != ZERO_REG);
    pop     = !Reset && (count != '0);
  end

  wb_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk        (Clk),
    .reset      (Reset),
    .push0      (aluPush),
    .pushData0  (aluEntry),
    .push1      (ldPush),
    .pushData1  (ldEntry),
    .pop        (pop),
    .count      (count),
    .rdPtr      (rdPtr),
    .head       (head),
    .entries    (entries),
    .entryValid (entryValid)
  );

  // Register-file write port driven straight from the queue head.
  always_comb begin
    wb.RegWr = pop;
    wb.RW    = '0;
    wb.BusW  = '0;
    if (pop) begin
      wb.RW   = head.rd;
      wb.BusW = head.data;
    end
  end

`ifdef WB_FORWARD_EN
  logic [PTR_W-1:0] fwdIdx;

  // Forwarding CAM: scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwdIdx      = '0;
    wb.FwdHitA  = 1'b0;
    wb.FwdHitB  = 1'b0;
    wb.FwdDataA = '0;
    wb.FwdDataB = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwdIdx = rdPtr + PTR_W'(i);
      if (entryValid[fwdIdx] && (entries[fwdIdx].rd == wb.FwdRA)) begin
        wb.FwdHitA  = 1'b1;
        wb.FwdDataA = entries[fwdIdx].data;
      end
      if (entryValid[fwdIdx] && (entries[fwdIdx].rd == wb.FwdRB)) begin
        wb.FwdHitB  = 1'b1;
        wb.FwdDataB = entries[fwdIdx].data;
      end
    end
    if (Reset || (wb.FwdRA == ZERO_REG)) begin
      wb.FwdHitA  = 1'b0;
      wb.FwdDataA = '0;
    end
    if (Reset || (wb.FwdRB == ZERO_REG)) begin
      wb.FwdHitB  = 1'b0;
      wb.FwdDataB = '0;
    end
  end
`else
  logic unusedFwd;

  // Forwarding disabled: outputs tied low, queue contents only feed the head.
  always_comb begin
    wb.FwdHitA  = 1'b0;
    wb.FwdHitB  = 1'b0;
    wb.FwdDataA = '0;
    wb.FwdDataB = '0;
    unusedFwd   = ^{wb.FwdRA, wb.FwdRB, entryValid, rdPtr};
    for (int unsigned i = 0; i < DEPTH; i++) begin
      unusedFwd = unusedFwd ^ (^entries[i]);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Self-checking bench for regfile_writeback_ctrl: directed vector table,
// hand sequences for multi-cycle corners, and random traffic against a queue model.
module tb_regfile_writeback_ctrl;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef WB_FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  typedef struct {
    logic        reset;
    logic        aluValid;
    logic [4:0]  aluRd;
    logic [63:0] aluData;
    logic        ldValid;
    logic [4:0]  ldRd;
    logic [63:0] ldData;
    logic [4:0]  fwdRA;
    logic [4:0]  fwdRB;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        expAluRdy;
    logic        expLdRdy;
    logic        expWr;
    logic [4:0]  expRw;
    logic [63:0] expBusW;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  stim_t cur;
  wb_entry_t q[$];
  vec_t tbl[11];

  regfile_writeback_ctrl_if wbIf();

  regfile_writeback_ctrl #(.DEPTH(DEPTH)) dut (
    .Clk   (clk),
    .Reset (reset),
    .wb    (wbIf)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic rst, input logic av, input logic [4:0] ard,
                               input logic [63:0] ad, input logic lv, input logic [4:0] lrd,
                               input logic [63:0] ld);
    stim_t s;
    s.reset = rst; s.aluValid = av; s.aluRd = ard; s.aluData = ad;
    s.ldValid = lv; s.ldRd = lrd; s.ldData = ld; s.fwdRA = 5'd0; s.fwdRB = 5'd0;
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    cur = s;
    reset = s.reset;
    wbIf.AluValid = s.aluValid; wbIf.AluRd = s.aluRd; wbIf.AluData = s.aluData;
    wbIf.LdValid = s.ldValid;   wbIf.LdRd = s.ldRd;   wbIf.LdData = s.ldData;
    wbIf.FwdRA = s.fwdRA;       wbIf.FwdRB = s.fwdRB;
    #1;
  endtask

  // Reference: youngest queued entry for register r.
  task automatic fwdModel(input logic [4:0] r, output logic hit, output logic [63:0] d);
    hit = 1'b0; d = '0;
    if (FWD_ON && !cur.reset && r != ZERO_REG)
      for (int i = 0; i < q.size(); i++)
        if (q[i].rd == r) begin hit = 1'b1; d = q[i].data; end
  endtask

  // Compare every output against the queue model for the current inputs.
  task automatic modelCheck(input string tag);
    int free;
    logic at, eh;
    logic [63:0] ed;
    free = int'(DEPTH) - q.size();
    at = cur.aluValid && cur.aluRd != ZERO_REG;
    chk({tag, ".AluReady"}, 64'(wbIf.AluReady), 64'(!cur.reset && free >= 1));
    chk({tag, ".LdReady"},  64'(wbIf.LdReady),  64'(!cur.reset && free >= 1 + int'(at)));
    chk({tag, ".RegWr"},    64'(wbIf.RegWr),    64'(!cur.reset && q.size() > 0));
    chk({tag, ".RW"},       64'(wbIf.RW),       (!cur.reset && q.size() > 0) ? 64'(q[0].rd) : 64'd0);
    chk({tag, ".BusW"},     wbIf.BusW,          (!cur.reset && q.size() > 0) ? q[0].data : 64'd0);
    fwdModel(cur.fwdRA, eh, ed);
    chk({tag, ".FwdHitA"},  64'(wbIf.FwdHitA),  64'(eh));
    chk({tag, ".FwdDataA"}, wbIf.FwdDataA,      ed);
    fwdModel(cur.fwdRB, eh, ed);
    chk({tag, ".FwdHitB"},  64'(wbIf.FwdHitB),  64'(eh));
    chk({tag, ".FwdDataB"}, wbIf.FwdDataB,      ed);
  endtask

  // Advance one clock and update the model from the spec's acceptance rules.
  task automatic tick();
    int free;
    logic at;
    free = int'(DEPTH) - q.size();
    at = cur.aluValid && cur.aluRd != ZERO_REG;
    @(posedge clk);
    if (cur.reset) q.delete();
    else begin
      if (q.size() > 0) void'(q.pop_front());
      if (at && free >= 1) q.push_back('{rd: cur.aluRd, data: cur.aluData});
      if (cur.ldValid && cur.ldRd != ZERO_REG && free >= 1 + int'(at))
        q.push_back('{rd: cur.ldRd, data: cur.ldData});
    end
    @(negedge clk);
  endtask

  initial begin
    stim_t s;
    logic expLd [6];
    expLd = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Directed table: reset, single write latency, dual ordering, XZR discard.
    tbl[0]  = '{mk(1, 1, 5,  64'hDEADBEEF, 0, 0,  0), 0, 0, 0, 5'd0, 64'd0};
    tbl[1]  = '{mk(0, 1, 5,  64'hDEADBEEF, 0, 0,  0), 1, 1, 0, 5'd0, 64'd0};
    tbl[2]  = '{mk(0, 0, 0,  0,            0, 0,  0), 1, 1, 1, 5'd5, 64'hDEADBEEF};
    tbl[3]  = '{mk(0, 0, 0,  0,            0, 0,  0), 1, 1, 0, 5'd0, 64'd0};
    tbl[4]  = '{mk(0, 1, 1,  64'h11,       1, 2,  64'h22), 1, 1, 0, 5'd0, 64'd0};
    tbl[5]  = '{mk(0, 0, 0,  0,            0, 0,  0), 1, 1, 1, 5'd1, 64'h11};
    tbl[6]  = '{mk(0, 0, 0,  0,            0, 0,  0), 1, 1, 1, 5'd2, 64'h22};
    tbl[7]  = '{mk(0, 1, 31, 64'h99,       0, 0,  0), 1, 1, 0, 5'd0, 64'd0};
    tbl[8]  = '{mk(0, 0, 0,  0,            0, 0,  0), 1, 1, 0, 5'd0, 64'd0};
    tbl[9]  = '{mk(0, 1, 31, 64'h77,       1, 31, 64'h88), 1, 1, 0, 5'd0, 64'd0};
    tbl[10] = '{mk(0, 0, 0,  0,            0, 0,  0), 1, 1, 0, 5'd0, 64'd0};

    drive(mk(1, 0, 0, 0, 0, 0, 0));
    tick();
    tick();

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].s);
      chk($sformatf("vec%0d.AluReady", i), 64'(wbIf.AluReady), 64'(tbl[i].expAluRdy));
      chk($sformatf("vec%0d.LdReady", i),  64'(wbIf.LdReady),  64'(tbl[i].expLdRdy));
      chk($sformatf("vec%0d.RegWr", i),    64'(wbIf.RegWr),    64'(tbl[i].expWr));
      chk($sformatf("vec%0d.RW", i),       64'(wbIf.RW),       64'(tbl[i].expRw));
      chk($sformatf("vec%0d.BusW", i),     wbIf.BusW,          tbl[i].expBusW);
      tick();
    end

    // Reset mid-operation with three entries queued.
    drive(mk(0, 1, 3, 64'h33, 1, 4, 64'h44)); tick();
    drive(mk(0, 1, 6, 64'h66, 1, 8, 64'h88));
    chk("rstseq.LdReadyAt2", 64'(wbIf.LdReady), 64'd1);
    tick();
    drive(mk(1, 0, 0, 0, 0, 0, 0));
    chk("rstseq.AluReadyInRst", 64'(wbIf.AluReady), 64'd0);
    chk("rstseq.LdReadyInRst",  64'(wbIf.LdReady),  64'd0);
    chk("rstseq.RegWrInRst",    64'(wbIf.RegWr),    64'd0);
    chk("rstseq.RWInRst",       64'(wbIf.RW),       64'd0);
    chk("rstseq.BusWInRst",     wbIf.BusW,          64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 0));
      chk($sformatf("rstseq.RegWrAfter%0d", i), 64'(wbIf.RegWr),    64'd0);
      chk($sformatf("rstseq.AluRdy%0d", i),     64'(wbIf.AluReady), 64'd1);
      chk($sformatf("rstseq.LdRdy%0d", i),      64'(wbIf.LdReady),  64'd1);
      tick();
    end

    // Forwarding: two writes to x7, youngest must win; x31 never hits.
    drive(mk(0, 1, 7, 64'hA, 1, 7, 64'hB)); tick();
    s = mk(0, 0, 0, 0, 0, 0, 0); s.fwdRA = 5'd7; s.fwdRB = 5'd31;
    drive(s);
    chk("fwd.HitA",  64'(wbIf.FwdHitA),  64'(FWD_ON));
    chk("fwd.DataA", wbIf.FwdDataA,      FWD_ON ? 64'hB : 64'd0);
    chk("fwd.HitB",  64'(wbIf.FwdHitB),  64'd0);
    chk("fwd.DataB", wbIf.FwdDataB,      64'd0);
    modelCheck("fwd0");
    tick();
    drive(s);
    chk("fwd.PopVisibleHit",  64'(wbIf.FwdHitA), 64'(FWD_ON));
    chk("fwd.PopVisibleData", wbIf.FwdDataA,     FWD_ON ? 64'hB : 64'd0);
    modelCheck("fwd1");
    tick();
    drive(s);
    chk("fwd.EmptyMiss", 64'(wbIf.FwdHitA), 64'd0);
    tick();

    // Back-pressure: offer ALU+load every cycle.
    for (int i = 0; i < 6; i++) begin
      drive(mk(0, 1, 5'(i + 1), 64'(100 + 2 * i), 1, 5'(i + 10), 64'(101 + 2 * i)));
      chk($sformatf("bp%0d.LdReady", i), 64'(wbIf.LdReady), 64'(expLd[i]));
      modelCheck($sformatf("bp%0d", i));
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 0));
      modelCheck($sformatf("drain%0d", i));
      tick();
    end

    // Random traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      s.reset    = ($urandom_range(0, 59) == 0);
      s.aluValid = ($urandom_range(0, 3) != 0);
      s.aluRd    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      s.aluData  = {$urandom(), $urandom()};
      s.ldValid  = ($urandom_range(0, 2) != 0);
      s.ldRd     = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      s.ldData   = {$urandom(), $urandom()};
      s.fwdRA    = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      s.fwdRB    = 5'($urandom_range(0, 31));
      drive(s);
      modelCheck($sformatf("rnd%0d", i));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
